// File: rtl/rx_framer_pkg.sv
// Shared definitions for the receive byte framer.
//   ENTRY_W  : FIFO entry width, a data byte plus its tlast flag
//   LAST_BIT : position of the tlast flag inside a FIFO entry
//   CNT_W    : width of the frame and drop status counters
//   state_t  : framer state, IDLE = nothing staged, HOLD = byte staged
//   sat_inc  : saturating increment for the status counters
package rx_framer_pkg;

  localparam int ENTRY_W  = 9;
  localparam int LAST_BIT = 8;
  localparam int CNT_W    = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rx_byte_framer_fifo.sv
// First-word fall-through synchronous FIFO.
//   clk_l   : clock
//   rst     : asynchronous active-low reset (pointers only)
//   clr     : synchronous flush, wins over reads and writes
//   wr_en   : write request; honoured when not full, or when full with a read
//   wr_data : entry to write
//   rd_en   : pop the head entry; ignored while empty
//   rd_data : head entry, forced to zero while empty
//   full    : DEPTH entries held
//   empty   : no entries held
//   level   : occupancy, 0..DEPTH
module sync_fifo_fwft #(
  parameter int DEPTH = 512,
  parameter int W     = 9
) (
  input  logic                     clk_l,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;

  logic w_wr;
  logic w_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = r_wptr - r_rptr;
  assign empty   = (r_wptr == r_rptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign w_rd    = rd_en & ~empty;
  // When full, a simultaneous read frees the slot being written.
  assign w_wr    = wr_en & (~full | w_rd);
  assign rd_data = empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_l or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; the empty mask keeps stale entries off rd_data.
  always_ff @(posedge clk_l) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rx_byte_framer.sv
// Groups the modem's received byte stream into frames of FRAME_LEN bytes
// with tlast, buffering them in a FWFT FIFO for the downstream packetiser.
// A partial frame is closed after TIMEOUT idle cycles. Input is never
// backpressured; bytes arriving at a full FIFO are dropped and counted.
//   clk_l         : modem rx byte clock
//   rst           : asynchronous active-low reset
//   clr           : synchronous flush of FIFO, staging and counters
//   s_axis_tdata  : byte from modem
//   s_axis_tvalid : byte valid
//   s_axis_tready : 1 once out of reset
//   m_axis_tdata  : byte to downstream (0 while empty)
//   m_axis_tvalid : FIFO not empty
//   m_axis_tlast  : last byte of a frame
//   m_axis_tready : downstream ready
//   fifo_level    : FIFO occupancy
//   frame_cnt     : frames stored in the FIFO, wrapping
//   drop_cnt      : bytes dropped on overflow, saturating
//   ovf_sticky    : set on the first drop
module rx_byte_framer
  import rx_framer_pkg::*;
#(
  parameter int DEPTH     = 512,
  parameter int FRAME_LEN = 188,
  parameter int TIMEOUT   = 1024,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic             clk_l,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [AW:0]      fifo_level,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             ovf_sticky
);

  localparam int              IW       = 21;
  localparam logic [IW-1:0]   IDLE_MAX = IW'(TIMEOUT - 1);
  localparam logic [15:0]     POS_LAST = 16'(FRAME_LEN - 1);

  state_t             r_state;
  logic               r_tready;
  logic [7:0]         r_stage_data;
  logic               r_stage_last;
  logic [15:0]        r_pos;
  logic [IW-1:0]      r_idle;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic               r_ovf;

  logic               w_accept;
  logic               w_stage_vld;
  logic               w_timeout;
  logic               w_push;
  logic               w_push_last;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_rd_data;

  assign w_accept    = s_axis_tvalid & r_tready;
  assign w_stage_vld = (r_state == ST_HOLD);
  // A new byte pre-empts the timeout: it pushes the staged byte itself.
  assign w_timeout   = w_stage_vld & ~w_accept & (r_idle == IDLE_MAX);
  assign w_push      = w_stage_vld & (w_accept | w_timeout);
  assign w_push_last = w_timeout | r_stage_last;
  assign w_pop       = ~w_empty & m_axis_tready;
  assign w_wr        = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_l   (clk_l),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (w_wr),
    .wr_data ({w_push_last, r_stage_data}),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk_l or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_tready     <= 1'b0;
      r_stage_last <= 1'b0;
      r_pos        <= '0;
      r_idle       <= '0;
      r_frame_cnt  <= '0;
      r_drop_cnt   <= '0;
      r_ovf        <= 1'b0;
    end else if (clr) begin
      r_state      <= ST_IDLE;
      r_tready     <= 1'b1;
      r_stage_last <= 1'b0;
      r_pos        <= '0;
      r_idle       <= '0;
      r_frame_cnt  <= '0;
      r_drop_cnt   <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      if (w_wr && w_push_last) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      if (w_drop) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
        r_ovf      <= 1'b1;
      end
      // Frame position advances on every accepted byte, dropped or not.
      if (w_accept) begin
        r_state      <= ST_HOLD;
        r_stage_last <= (r_pos == POS_LAST);
        r_pos        <= (r_pos == POS_LAST) ? '0 : r_pos + 16'd1;
        r_idle       <= '0;
      end else begin
        case (r_state)
          ST_IDLE: r_idle <= '0;
          ST_HOLD: begin
            if (w_timeout) begin
              r_state <= ST_IDLE;
              r_pos   <= '0;
              r_idle  <= '0;
            end else begin
              r_idle  <= r_idle + IW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Staged byte value needs no reset; the HOLD state qualifies it.
  always_ff @(posedge clk_l) begin
    if (w_accept) r_stage_data <= s_axis_tdata;
  end

  assign s_axis_tready = r_tready;
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = w_rd_data[7:0];
  assign m_axis_tlast  = w_rd_data[LAST_BIT];
  assign frame_cnt     = r_frame_cnt;
  assign drop_cnt      = r_drop_cnt;
  assign ovf_sticky    = r_ovf;

endmodule

// File: tb/tb_rx_byte_framer.sv
module tb_rx_byte_framer;

  localparam int DEPTH = 4;
  localparam int FL    = 4;
  localparam int TO    = 8;
  localparam int AW    = $clog2(DEPTH);

  logic        clk_l = 1'b0;
  logic        rst   = 1'b0;
  logic        clr   = 1'b0;
  logic [7:0]  s_axis_tdata  = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [AW:0] fifo_level;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        ovf_sticky;

  rx_byte_framer #(
    .DEPTH     (DEPTH),
    .FRAME_LEN (FL),
    .TIMEOUT   (TO)
  ) dut (
    .clk_l         (clk_l),
    .rst           (rst),
    .clr           (clr),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .fifo_level    (fifo_level),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt),
    .ovf_sticky    (ovf_sticky)
  );

  always #5 clk_l = ~clk_l;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: a queue of stored (last,byte) entries plus one held byte.
  logic [8:0] q[$];
  logic [8:0] got[$];
  logic [7:0] m_stage;
  bit         m_stage_last;
  bit         m_have;
  int         m_pos;
  int         m_idle;
  int         m_frame;
  int         m_drop;
  bit         m_ovf;
  bit         m_tready;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_clear(input bit tready_after);
    q.delete();
    m_have   = 0;
    m_stage_last = 0;
    m_pos    = 0;
    m_idle   = 0;
    m_frame  = 0;
    m_drop   = 0;
    m_ovf    = 0;
    m_tready = tready_after;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit rd, input bit c);
    bit         acc;
    bit         push;
    bit         pop;
    bit         full;
    logic [8:0] item;
    if (c) begin
      model_clear(1'b1);
      return;
    end
    acc  = v && m_tready;
    push = 0;
    item = '0;
    if (m_have && acc) begin
      push = 1;
      item = {m_stage_last, m_stage};
    end else if (m_have && m_idle == TO - 1) begin
      push   = 1;
      item   = {1'b1, m_stage};
      m_have = 0;
      m_pos  = 0;
      m_idle = 0;
    end else if (m_have) begin
      m_idle++;
    end
    if (acc) begin
      m_stage      = d;
      m_stage_last = (m_pos == FL - 1);
      m_pos        = (m_pos + 1) % FL;
      m_idle       = 0;
      m_have       = 1;
    end
    full = (q.size() == DEPTH);
    pop  = (q.size() > 0) && rd;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (!full || pop) begin
        q.push_back(item);
        if (item[8]) m_frame = (m_frame + 1) % 65536;
      end else begin
        if (m_drop < 65535) m_drop++;
        m_ovf = 1;
      end
    end
    m_tready = 1;
  endtask

  task automatic check_all();
    logic [8:0] head;
    head = (q.size() > 0) ? q[0] : 9'h000;
    chk("tvalid", 32'(m_axis_tvalid), 32'(q.size() > 0));
    chk("tdata",  32'(m_axis_tdata),  32'(head[7:0]));
    chk("tlast",  32'(m_axis_tlast),  32'(head[8]));
    chk("level",  32'(fifo_level),    32'(q.size()));
    chk("frames", 32'(frame_cnt),     32'(m_frame));
    chk("drops",  32'(drop_cnt),      32'(m_drop));
    chk("ovf",    32'(ovf_sticky),    32'(m_ovf));
    chk("tready", 32'(s_axis_tready), 32'(m_tready));
  endtask

  // Called at a negedge: drive one cycle of inputs, advance model, check after edge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit rd, input bit c);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = rd;
    clr           = c;
    if (!c && m_axis_tvalid && rd) got.push_back({m_axis_tlast, m_axis_tdata});
    model_step(v, d, rd, c);
    @(negedge clk_l);
    cyc++;
    check_all();
  endtask

  task automatic chk_zero_outputs(input string tag, input bit exp_tready);
    chk({tag, "_tready"}, 32'(s_axis_tready), 32'(exp_tready));
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
    chk({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
    chk({tag, "_level"},  32'(fifo_level),    32'd0);
    chk({tag, "_frames"}, 32'(frame_cnt),     32'd0);
    chk({tag, "_drops"},  32'(drop_cnt),      32'd0);
    chk({tag, "_ovf"},    32'(ovf_sticky),    32'd0);
  endtask

  initial begin
    int acc_cyc;
    int seen_cyc;
    int pv;
    int pr;
    logic [8:0] exp4 [6];

    // Reset state
    model_clear(1'b0);
    #1;
    chk_zero_outputs("reset", 1'b0);
    @(negedge clk_l);
    @(negedge clk_l);
    rst = 1'b1;
    cycle(0, 8'h00, 1, 0);

    // Two full frames, then idle
    got.delete();
    for (int i = 0; i < 8; i++) cycle(1, 8'(i), 1, 0);
    for (int i = 0; i < 12; i++) cycle(0, 8'h00, 1, 0);
    chk("t1_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("t1_byte", 32'(got[i]), {23'd0, (i == 3 || i == 7), 8'(i)});
    chk("t1_frames", 32'(frame_cnt), 32'd2);
    chk("t1_drops",  32'(drop_cnt),  32'd0);

    // Short burst closed by timeout
    cycle(0, 8'h00, 1, 1);
    got.delete();
    cycle(1, 8'hA0, 1, 0);
    acc_cyc  = cyc;
    cycle(1, 8'hA1, 1, 0);
    seen_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 8'h00, 1, 0);
      if (seen_cyc < 0 && m_axis_tvalid && m_axis_tdata == 8'hA1) begin
        seen_cyc = cyc;
        chk("t2_a1_last", 32'(m_axis_tlast), 32'd1);
      end
    end
    chk("t2_a1_delay", 32'(seen_cyc - acc_cyc), 32'd9);
    chk("t2_frames", 32'(frame_cnt), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1, 8'hB0 + 8'(i), 1, 0);
    cycle(0, 8'h00, 1, 0);
    chk("t2_count", 32'(got.size()), 32'd6);
    if (got.size() >= 6) chk("t2_b3", 32'(got[5]), 32'h1B3);

    // Overflow with downstream stalled
    cycle(0, 8'h00, 0, 1);
    got.delete();
    for (int i = 0; i < 10; i++) cycle(1, 8'h10 + 8'(i), 0, 0);
    chk("t3_level", 32'(fifo_level),    32'd4);
    chk("t3_drops", 32'(drop_cnt),      32'd5);
    chk("t3_ovf",   32'(ovf_sticky),    32'd1);
    chk("t3_head",  32'(m_axis_tdata),  32'h10);
    chk("t3_ready", 32'(s_axis_tready), 32'd1);

    // Full FIFO with a pop and a push in the same cycle
    cycle(1, 8'h1A, 1, 0);
    chk("t4_level", 32'(fifo_level), 32'd4);
    chk("t4_drops", 32'(drop_cnt),   32'd5);
    for (int i = 0; i < 12; i++) cycle(0, 8'h00, 1, 0);
    exp4 = '{9'h010, 9'h011, 9'h012, 9'h113, 9'h019, 9'h11A};
    chk("t4_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("t4_byte", 32'(got[i]), 32'(exp4[i]));
    chk("t4_frames", 32'(frame_cnt), 32'd2);

    // Randomised traffic
    cycle(0, 8'h00, 1, 1);
    pv = 90;
    pr = 100;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       pv = 95;
          1:       pv = 50;
          default: pv = 8;
        endcase
        case ($urandom_range(0, 2))
          0:       pr = 100;
          1:       pr = 50;
          default: pr = 15;
        endcase
      end
      cycle($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pr,
            $urandom_range(0, 299) == 0);
    end

    // clr with three bytes stored and one staged
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 8'h30 + 8'(i), 0, 0);
    chk("t6_level", 32'(fifo_level), 32'd3);
    cycle(0, 8'h00, 0, 1);
    chk_zero_outputs("clr", 1'b1);
    for (int i = 0; i < 12; i++) cycle(0, 8'h00, 1, 0);
    chk("t6_quiet", 32'(m_axis_tvalid), 32'd0);

    // Asynchronous reset mid-stream
    cycle(1, 8'h40, 0, 0);
    cycle(1, 8'h41, 0, 0);
    cycle(1, 8'h42, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_zero_outputs("rst", 1'b0);
    model_clear(1'b0);
    s_axis_tvalid = 1'b0;
    @(negedge clk_l);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) cycle(0, 8'h00, 1, 0);
    chk("t7_quiet", 32'(m_axis_tvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
